// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and helpers for the BCD display path
//
// Purpose: segment patterns (active-low {g,f,e,d,c,b,a}), the six-digit range limit,
//          FSM state encoding and small helper functions for io_bcd_display.
// Ports:   none (package).
package io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [31:0] BCD_LIMIT = 32'd1_000_000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  // Active-low pattern for one BCD nibble; 10-15 cannot occur and show blank.
  function automatic logic [6:0] seg_lut(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Patterns are stored active-low; active-high boards get the complement.
  function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input bit active_low);
    return active_low ? pattern : ~pattern;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the next shift.
  function automatic logic [23:0] bcd_adjust(input logic [23:0] bcd);
    logic [23:0] res;
    res = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - one BCD nibble to 7-segment pattern
//
// Purpose: combinational nibble decode with blank and dash overrides.
// Ports:   digit  in  4  BCD nibble
//          blank  in  1  force all segments off
//          dash   in  1  force segment g only (overrides blank)
//          seg    out 7  {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
module seg7_decode
  import io_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] seg_raw;

  always_comb begin
    seg_raw = seg_lut(digit);
    if (blank) seg_raw = SEG_BLANK;
    if (dash)  seg_raw = SEG_DASH;
  end

  assign seg = seg_polarity(seg_raw, SEG_ACTIVE_LOW != 0);

endmodule

// File: rtl/io_bcd_display.sv
// rtl/io_bcd_display.sv - binary value to six 7-segment digits via serial double-dabble
//
// Purpose: watches an out_port value, converts it one bit per clock when it changes and
//          updates the six displays in a single LATCH cycle so they never glitch.
//          Optional macro IO_BCD_BLANK_EN enables leading-zero blanking.
// Ports:   clock     in  1       rising-edge clock
//          resetn    in  1       asynchronous active-low reset
//          value     in  DATA_W  unsigned value to display
//          busy      out 1       conversion in progress (SHIFT or LATCH)
//          overflow  out 1       displayed value was >= 1_000_000 (dashes shown)
//          hex0..5   out 7       ones .. hundred-thousands digit segments
module io_bcd_display
  import io_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int EXT_W = (DATA_W > 32) ? DATA_W : 32;

  localparam logic [6:0] RST_LOW = seg_polarity(SEG_0, SEG_ACTIVE_LOW != 0);
`ifdef IO_BCD_BLANK_EN
  localparam logic [6:0] RST_UPPER = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW != 0);
`else
  localparam logic [6:0] RST_UPPER = RST_LOW;
`endif

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] last_value;
  logic [23:0]       bcd;
  logic              ovf_pend;

  logic [23:0]          bcd_adj;
  logic [DATA_W+23:0]   shifted;
  logic [EXT_W-1:0]     value_ext;
  logic                 value_ovf;
  logic [5:0]           blank;
  logic [6:0]           seg_next [6];

  assign busy      = (state != ST_IDLE);
  assign bcd_adj   = bcd_adjust(bcd);
  // The top bit of bcd_adj falls off here; values reaching SHIFT are < 1_000_000 so it is always 0.
  assign shifted   = {bcd_adj, shift_reg} << 1;
  assign value_ext = EXT_W'(value);
  assign value_ovf = (value_ext >= EXT_W'(BCD_LIMIT));

  // Blank every digit above the most significant non-zero one; hex0 always shows.
  always_comb begin
    blank = '0;
`ifdef IO_BCD_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = 5; i >= 1; i--) begin
        zero_run = zero_run && (bcd[4*i +: 4] == 4'd0);
        blank[i] = zero_run;
      end
    end
`endif
  end

  for (genvar i = 0; i < 6; i++) begin : g_digit
    seg7_decode #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .digit(bcd[4*i +: 4]),
      .blank(blank[i]),
      .dash (ovf_pend),
      .seg  (seg_next[i])
    );
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      last_value <= '0;
      bcd        <= '0;
      ovf_pend   <= 1'b0;
      overflow   <= 1'b0;
      hex0       <= RST_LOW;
      hex1       <= RST_UPPER;
      hex2       <= RST_UPPER;
      hex3       <= RST_UPPER;
      hex4       <= RST_UPPER;
      hex5       <= RST_UPPER;
    end else begin
      case (state)
        ST_IDLE: begin
          if (value != last_value) begin
            shift_reg  <= value;
            last_value <= value;
            bcd        <= '0;
            cnt        <= '0;
            ovf_pend   <= value_ovf;
            // Out-of-range values skip the shift phase entirely and show dashes.
            state      <= value_ovf ? ST_LATCH : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd       <= shifted[DATA_W+23:DATA_W];
          shift_reg <= shifted[DATA_W-1:0];
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= ST_LATCH;
        end
        ST_LATCH: begin
          overflow <= ovf_pend;
          hex0     <= seg_next[0];
          hex1     <= seg_next[1];
          hex2     <= seg_next[2];
          hex3     <= seg_next[3];
          hex4     <= seg_next[4];
          hex5     <= seg_next[5];
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bcd_display.sv
// tb/tb_io_bcd_display.sv - self-checking bench for io_bcd_display
module tb_io_bcd_display;

  localparam int DATA_W = 32;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] value  = '0;
  logic        busy;
  logic        overflow;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  always #5 clock = ~clock;

  io_bcd_display #(
    .DATA_W        (DATA_W),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .value   (value),
    .busy    (busy),
    .overflow(overflow),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3),
    .hex4    (hex4),
    .hex5    (hex5)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  // Expected {overflow, hex5..hex0} once value v has been latched.
  function automatic logic [42:0] model(input int unsigned v);
    logic [42:0] r;
    int unsigned pw;
    r  = '0;
    pw = 1;
    if (v >= 1000000) return {1'b1, {6{7'b0111111}}};
    for (int i = 0; i < 6; i++) begin
      r[7*i +: 7] = seg_of((v / pw) % 10);
`ifdef IO_BCD_BLANK_EN
      if (i > 0 && v < pw) r[7*i +: 7] = 7'h7f;
`endif
      pw = pw * 10;
    end
    return r;
  endfunction

  logic [42:0] obs;
  assign obs = {overflow, hex5, hex4, hex3, hex2, hex1, hex0};

  int unsigned val_q[$];
  int unsigned last_drv = 0;
  logic [42:0] shown;
  bit          prev_busy = 1'b0;

  // Pops an expectation at each falling busy; otherwise outputs must hold.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_busy = 1'b0;
      shown     = model(0);
    end else begin
      if (prev_busy && !busy) begin
        if (val_q.size() == 0) begin
          check("pending_results", val_q.size(), 1);
        end else begin
          int unsigned v;
          v     = val_q.pop_front();
          shown = model(v);
          check($sformatf("conv_%0d", v), obs, shown);
        end
      end else begin
        check("stable", obs, shown);
      end
      prev_busy = busy;
    end
  end

  task automatic drive(input int unsigned v);
    value = v;
    if (v != last_drv) val_q.push_back(v);
    last_drv = v;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    repeat (2) @(negedge clock);
    while ((busy || val_q.size() != 0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("drained", val_q.size(), 0);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    repeat (DATA_W + 8) begin
      @(negedge clock);
      if (busy) n++;
    end
  endtask

  initial begin
    int n;
    shown = model(0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    measure_busy(n);
    check("idle_busy", n, 0);
    check("reset_disp", obs, model(0));

    drive(123456);
    measure_busy(n);
    check("busy_len", n, DATA_W + 1);
    wait_done(100);
    check("no_ovf", overflow, 0);

    drive(999999);
    wait_done(100);
    drive(1000000);
    measure_busy(n);
    check("ovf_busy_len", n, 1);
    wait_done(100);
    check("ovf_flag", overflow, 1);

    drive(32'hFFFF_FFFF);
    wait_done(100);
    drive(0);
    wait_done(100);
    check("ovf_cleared", overflow, 0);

    drive(42);
    repeat (10) @(negedge clock);
    drive(7);
    wait_done(200);

    drive(3);
    wait_done(100);
    drive(3);
    measure_busy(n);
    check("same_value_busy", n, 0);

    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(1, 999999));
      wait_done(100);
    end

    drive(555555);
    repeat (10) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_disp", obs, model(0));
    check("async_reset_busy", busy, 0);
    val_q.delete();
    last_drv = 0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    val_q.push_back(555555);
    last_drv = 555555;
    wait_done(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
